// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_pkg
// Purpose  : Shared types and constants for the RTC multiplexed bus engine:
//            FSM state encoding, default phase length and RTC register map.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_ACT = 3'd1,
    ST_ADDR_REL = 3'd2,
    ST_DATA_ACT = 3'd3,
    ST_DATA_REL = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam int unsigned c_T_PHASE_DEFAULT = 10;

  // RTC register map
  localparam logic [7:0] c_SEG          = 8'h21;
  localparam logic [7:0] c_MIN          = 8'h22;
  localparam logic [7:0] c_HORA         = 8'h23;
  localparam logic [7:0] c_DIA          = 8'h24;
  localparam logic [7:0] c_MES          = 8'h25;
  localparam logic [7:0] c_ANO          = 8'h26;
  localparam logic [7:0] c_CMD_TRANSFER = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : rtc_phase_timer
// Purpose  : 8-bit load/decrement phase counter. Loads load_val on load,
//            counts down while dec is high and saturates at zero.
// Ports    : clk, Reset      - clock, synchronous active-high reset
//            load, load_val  - reload request and value
//            dec             - decrement enable
//            tc              - terminal count (counter is zero)
// Revision : 1.0 - initial release
// ============================================================================
module rtc_phase_timer (
  input  logic       clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       tc
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != 8'd0)) begin
      // Saturating: the counter must never wrap past zero.
      r_count <= r_count - 8'd1;
    end
  end

  assign tc = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_engine.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_engine
// Purpose  : Sequences one read or write on a multiplexed address/data RTC
//            bus: address phase (active + hold), data phase (active + hold),
//            then a one-cycle DONE. All pad and status outputs are registered.
// Ports    : clk, Reset               - clock, synchronous active-high reset
//            req, we, addr, wdata     - transaction request (sampled in IDLE)
//            busy, done, rdata        - status, completion pulse, read data
//            cs_n, rd_n, wr_n, ad_n   - active-low RTC strobes, addr/data sel
//            bus_out, bus_oe, bus_in  - pad drive value, enable, read-back
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_engine
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PHASE  = c_T_PHASE_DEFAULT,
  parameter logic [7:0]  IDLE_BUS = 8'hFF
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  localparam logic [7:0] c_PHASE_LOAD = 8'(T_PHASE - 1);

  state_t     r_state;
  state_t     w_next;
  logic       w_load;
  logic       w_dec;
  logic       w_tc;

  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;

  // Transaction fields seen by the output decode: on the accept edge the
  // capture registers are not yet loaded, so take the live inputs.
  logic       w_txn_we;
  logic [7:0] w_txn_addr;
  logic [7:0] w_txn_wdata;

  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rdata;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_wr_n;
  logic       r_ad_n;
  logic [7:0] r_bus_out;
  logic       r_bus_oe;

  rtc_phase_timer u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .load     (w_load),
    .load_val (c_PHASE_LOAD),
    .dec      (w_dec),
    .tc       (w_tc)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_next = ST_ADDR_ACT;
          w_load = 1'b1;
        end
      end
      ST_ADDR_ACT: begin
        if (w_tc) begin
          w_next = ST_ADDR_REL;
          w_load = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_ADDR_REL: begin
        if (w_tc) begin
          w_next = ST_DATA_ACT;
          w_load = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DATA_ACT: begin
        if (w_tc) begin
          w_next = ST_DATA_REL;
          w_load = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DATA_REL: begin
        if (w_tc) begin
          w_next = ST_DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_txn_we    = r_we;
    w_txn_addr  = r_addr;
    w_txn_wdata = r_wdata;
    if (r_state == ST_IDLE) begin
      w_txn_we    = we;
      w_txn_addr  = addr;
      w_txn_wdata = wdata;
    end
  end

  // State and all outputs registered together; outputs are decoded from the
  // state being entered so they line up exactly with the phase boundaries.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= 8'h00;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_ad_n    <= 1'b1;
      r_bus_oe  <= 1'b0;
      r_bus_out <= IDLE_BUS;
    end else begin
      r_state <= w_next;
      r_we    <= w_txn_we;
      r_addr  <= w_txn_addr;
      r_wdata <= w_txn_wdata;

      // Read data is sampled on the last cycle the read strobe is low.
      if ((r_state == ST_DATA_ACT) && w_tc && !r_we) begin
        r_rdata <= bus_in;
      end

      r_busy    <= (w_next != ST_IDLE);
      r_done    <= (w_next == ST_DONE);
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
      r_ad_n    <= 1'b1;
      r_bus_oe  <= 1'b0;
      r_bus_out <= IDLE_BUS;

      case (w_next)
        ST_ADDR_ACT: begin
          // wr_n doubles as the address latch strobe in this phase.
          r_cs_n    <= 1'b0;
          r_ad_n    <= 1'b0;
          r_wr_n    <= 1'b0;
          r_bus_oe  <= 1'b1;
          r_bus_out <= w_txn_addr;
        end
        ST_ADDR_REL: begin
          r_ad_n    <= 1'b0;
          r_bus_oe  <= 1'b1;
          r_bus_out <= w_txn_addr;
        end
        ST_DATA_ACT: begin
          r_cs_n <= 1'b0;
          if (w_txn_we) begin
            r_wr_n    <= 1'b0;
            r_bus_oe  <= 1'b1;
            r_bus_out <= w_txn_wdata;
          end else begin
            r_rd_n <= 1'b0;
          end
        end
        ST_DATA_REL: begin
          if (w_txn_we) begin
            r_bus_oe  <= 1'b1;
            r_bus_out <= w_txn_wdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign cs_n    = r_cs_n;
  assign rd_n    = r_rd_n;
  assign wr_n    = r_wr_n;
  assign ad_n    = r_ad_n;
  assign bus_oe  = r_bus_oe;
  assign bus_out = r_bus_out;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bus_engine
// Purpose  : Self-checking bench for rtc_bus_engine with T_PHASE=4. A
//            cycle-offset reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_engine;
  import rtc_bus_pkg::*;

  localparam int TP   = 4;
  localparam int TLEN = 4 * TP + 1;

  logic       clk;
  logic       Reset;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_n;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic [7:0] rtc_val;

  rtc_bus_engine #(.T_PHASE(TP), .IDLE_BUS(8'hFF)) dut (
    .clk(clk), .Reset(Reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RTC model: drives its register value only while the read strobe is low.
  assign bus_in = (rd_n === 1'b0) ? rtc_val : 8'hA5;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_seen   = 0;
  bit saw_23      = 0;

  // Reference model: transaction described only by its cycle offset k from
  // the accept edge (1..TLEN), 0 when idle.
  bit         m_active;
  int         m_k;
  bit         m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (Reset) begin
      m_active = 0;
      m_k      = 0;
      m_rdata  = 8'h00;
    end else if (!m_active) begin
      if (req) begin
        m_active = 1;
        m_k      = 1;
        m_we     = we;
        m_addr   = addr;
        m_wdata  = wdata;
      end
    end else begin
      if (m_k == 3 * TP && !m_we) m_rdata = rtc_val;
      if (m_k == TLEN) begin
        m_active = 0;
        m_k      = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic check_outputs();
    logic e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done;
    logic [7:0] e_bus;
    int p;
    e_cs = 1; e_rd = 1; e_wr = 1; e_ad = 1; e_oe = 0; e_bus = 8'hFF;
    e_busy = m_active;
    e_done = m_active && (m_k == TLEN);
    if (m_active && m_k < TLEN) begin
      p = (m_k - 1) / TP;
      case (p)
        0: begin e_cs = 0; e_ad = 0; e_wr = 0; e_oe = 1; e_bus = m_addr; end
        1: begin e_ad = 0; e_oe = 1; e_bus = m_addr; end
        2: begin
          e_cs = 0;
          if (m_we) begin e_wr = 0; e_oe = 1; e_bus = m_wdata; end
          else e_rd = 0;
        end
        default: begin
          if (m_we) begin e_oe = 1; e_bus = m_wdata; end
        end
      endcase
    end
    chk("ctrl{busy,done,cs,rd,wr,ad,oe}",
        {25'd0, busy, done, cs_n, rd_n, wr_n, ad_n, bus_oe},
        {25'd0, e_busy, e_done, e_cs, e_rd, e_wr, e_ad, e_oe});
    chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
    if (e_oe) chk("bus_out", {24'd0, bus_out}, {24'd0, e_bus});
    chk("rd_wr_both_low", {31'd0, (rd_n === 1'b0 && wr_n === 1'b0)}, 32'd0);
    chk("oe_during_read", {31'd0, (bus_oe === 1'b1 && rd_n === 1'b0)}, 32'd0);
    if (done === 1'b1) done_seen++;
    if (bus_oe === 1'b1 && bus_out === 8'h23) saw_23 = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic start_txn(input bit w, input logic [7:0] a, input logic [7:0] d);
    req = 1; we = w; addr = a; wdata = d;
    step();
    req = 0; addr = 8'($urandom); wdata = 8'($urandom); we = 1'($urandom);
  endtask

  initial begin
    int t;
    int done_cyc;
    m_active = 0; m_k = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    // Reset with a simultaneous request: the request must be ignored.
    Reset = 1; req = 1; we = 1; addr = 8'h55; wdata = 8'hAA; rtc_val = 8'h00;
    repeat (3) step();
    chk("reset_idle_busy", {31'd0, busy}, 32'd0);
    Reset = 0; req = 0;
    step();

    // Write SEG = 0x59
    start_txn(1, c_SEG, 8'h59);
    repeat (TLEN + 1) step();

    // Read MIN, RTC returns 0x13
    rtc_val = 8'h13;
    start_txn(0, c_MIN, 8'h00);
    repeat (TLEN + 1) step();
    chk("read_rdata_13", {24'd0, rdata}, 32'h13);

    // Collision: second request in cycle 5 must be dropped
    done_seen = 0; saw_23 = 0;
    start_txn(1, c_DIA, 8'h31);
    repeat (4) step();
    req = 1; we = 1; addr = c_HORA;
    step();
    req = 0; addr = 8'h00;
    repeat (TLEN) step();
    chk("collision_done_count", done_seen, 1);
    chk("collision_addr23_seen", {31'd0, saw_23}, 32'd0);

    // Reset during cycle 10 of a write aborts it
    done_seen = 0;
    start_txn(1, c_ANO, 8'h77);
    repeat (9) step();
    Reset = 1;
    step();
    Reset = 0;
    chk("abort_outputs{cs,rd,wr,oe,busy}",
        {27'd0, cs_n, rd_n, wr_n, bus_oe, busy}, {27'd0, 5'b11100});
    repeat (TLEN) step();
    chk("abort_no_done", done_seen, 0);

    // Two back-to-back reads with req held high
    rtc_val = 8'h3C;
    req = 1; we = 0; addr = c_MES;
    step();
    t = 0;
    while (done !== 1'b1 && t < 40) begin step(); t++; end
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    done_cyc = cyc;
    addr = c_ANO; rtc_val = 8'hC3;
    t = 0;
    while (!(cs_n === 1'b0 && ad_n === 1'b0) && t < 10) begin step(); t++; end
    chk("b2b_gap_cycles", cyc - done_cyc, 2);
    req = 0;
    repeat (TLEN + 2) step();
    chk("b2b_second_rdata", {24'd0, rdata}, 32'hC3);

    // Randomized traffic with occasional resets
    repeat (30) begin
      we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      rtc_val = 8'($urandom);
      req = ($urandom_range(0, 3) != 0);
      Reset = ($urandom_range(0, 40) == 0);
      step();
      repeat ($urandom_range(1, 22)) begin
        req = ($urandom_range(0, 7) == 0);
        addr = 8'($urandom); wdata = 8'($urandom); we = 1'($urandom);
        Reset = ($urandom_range(0, 80) == 0);
        step();
      end
    end
    Reset = 0; req = 0;
    repeat (TLEN + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
